// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle for serial_addsub.
interface serial_addsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_digit_adder.sv
// DIGIT-bit ripple chain of full adders with MSB carry tap.
module digit_adder
  import adder_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i])
               | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice per clock.
module serial_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_addsub_if.slave io
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  logic [DIGIT-1:0] d_sum;
  logic             d_cout;
  logic             d_cmsb;
  logic             accept;
  logic             last;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_slice (
    .a     (a_sr[DIGIT-1:0]),
    .b     (b_sr[DIGIT-1:0]),
    .cin   (carry),
    .sum   (d_sum),
    .cout  (d_cout),
    .c_msb (d_cmsb)
  );

  // busy_q lags state by a cycle, so a new
  // request waits until busy has dropped.
  assign accept = (state == IDLE)
                & io.start & ~busy_q;
  assign last   = (cnt == LAST);

  assign r_nxt = (r_sr >> DIGIT)
               | (WIDTH'(d_sum) << (WIDTH - DIGIT));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      carry  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      busy_q <= (state != IDLE);
      done_q <= (state == DONE);
      if (accept) begin
        a_sr  <= io.a;
        b_sr  <= io.sub ? ~io.b : io.b;
        carry <= io.cin ^ io.sub;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sr  <= a_sr >> DIGIT;
        b_sr  <= b_sr >> DIGIT;
        r_sr  <= r_nxt;
        carry <= d_cout;
        cnt   <= cnt + 1'b1;
        if (last) begin
          sum_q  <= r_nxt;
          cout_q <= d_cout;
          ovf_q  <= d_cout ^ d_cmsb;
        end
      end
    end
  end

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.sum  = sum_q;
  assign io.cout = cout_q;
  assign io.ovf  = ovf_q;

endmodule
